// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port synchronous RAM: arbitrates one RAM
// access per cycle between push and pop, and keeps the head word in a register.
module ram_fifo_ctrl #(
    parameter int DEPTH = 256,
    parameter int AWID  = 8,
    parameter int DWID  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DWID-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DWID-1:0] out_data,
    output logic [AWID:0]   count,
    output logic            ram_we,
    output logic [AWID-1:0] ram_addr,
    output logic [DWID-1:0] ram_din,
    input  logic [DWID-1:0] ram_dout
);

    typedef enum logic {IDLE, RD_WAIT} state_t;
    typedef enum logic {READ, WRITE} grant_t;

    localparam logic [AWID:0]   FULL = (AWID+1)'(DEPTH);
    localparam logic [AWID-1:0] LAST = AWID'(DEPTH - 1);

    state_t          state;
    grant_t          last_grant;
    logic [AWID-1:0] wr_ptr;
    logic [AWID-1:0] rd_ptr;
    logic [AWID:0]   ram_cnt;
    logic            ov_q;

    logic            active;
    logic            rd_want;
    logic            wr_want;
    logic            rd_grant;
    logic            wr_grant;
    logic            pop;
    logic            capture;
    logic            ov_nxt;
    logic [AWID:0]   ram_cnt_nxt;

    // On a conflict the access type not granted last time wins, so neither side starves.
    always_comb begin
        active      = rst_n && !clr;
        rd_want     = active && (state == IDLE) && (ram_cnt != '0) && (!ov_q || out_ready);
        wr_want     = active && in_valid && (ram_cnt < FULL);
        rd_grant    = rd_want && (!wr_want || (last_grant == WRITE));
        wr_grant    = wr_want && !rd_grant;
        pop         = active && ov_q && out_ready;
        capture     = active && (state == RD_WAIT);
        ov_nxt      = capture ? 1'b1 : (pop ? 1'b0 : ov_q);
        ram_cnt_nxt = ram_cnt + (AWID+1)'(wr_grant) - (AWID+1)'(rd_grant);
    end

    assign in_ready  = active && (ram_cnt < FULL) && !rd_grant;
    assign out_valid = ov_q && !clr;
    assign ram_we    = wr_grant;
    assign ram_addr  = wr_grant ? wr_ptr : (rst_n ? rd_ptr : '0);
    assign ram_din   = rst_n ? in_data : '0;

    // Flush and reset share one path; an in-flight read is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state      <= IDLE;
            last_grant <= READ;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            ov_q       <= 1'b0;
            out_data   <= '0;
            count      <= '0;
        end else begin
            state   <= rd_grant ? RD_WAIT : IDLE;
            ov_q    <= ov_nxt;
            ram_cnt <= ram_cnt_nxt;
            count   <= ram_cnt_nxt + (AWID+1)'(rd_grant) + (AWID+1)'(ov_nxt);
            if (capture) begin
                out_data <= ram_dout;
            end
            if (rd_grant) begin
                last_grant <= READ;
                rd_ptr     <= (rd_ptr == LAST) ? '0 : rd_ptr + AWID'(1);
            end else if (wr_grant) begin
                last_grant <= WRITE;
                wr_ptr     <= (wr_ptr == LAST) ? '0 : wr_ptr + AWID'(1);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (ram_cnt <= FULL);
            assert (!(rd_grant && (ram_cnt == '0)));
        end
    end

endmodule
